// File: rtl/simd_iter_loop_addr_gen.sv
// SIMD iterator unit: per-namespace base/stride tables plus a hardware loop sequencer.
// Optional modular wrap of the base write-back at ADDR_LIMIT is enabled by defining ITER_ADDR_WRAP_EN.
module simd_iter_loop_addr_gen #(
  parameter int NUM_NS           = 6,
  parameter int NS_ID_BITS       = 3,
  parameter int NS_INDEX_ID_BITS = 5,
  parameter int OPCODE_BITS      = 4,
  parameter int FUNCTION_BITS    = 4,
  parameter int IMM_W            = 16,
  parameter int ADDR_W           = 32,
  parameter int CNT_W            = 16,
  parameter int ADDR_LIMIT       = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic [OPCODE_BITS-1:0]      opcode,
  input  logic [FUNCTION_BITS-1:0]    fn,
  input  logic [NS_ID_BITS-1:0]       dest_ns_id,
  input  logic [NS_ID_BITS-1:0]       src1_ns_id,
  input  logic [NS_ID_BITS-1:0]       src2_ns_id,
  input  logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
  input  logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
  input  logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
  input  logic                        src1_use,
  input  logic                        src2_use,
  input  logic                        dest_use,
  input  logic                        loop_start,
  input  logic [CNT_W-1:0]            loop_count,
  output logic                        addr_valid,
  input  logic                        addr_ready,
  output logic [ADDR_W-1:0]           src1_addr,
  output logic [ADDR_W-1:0]           src2_addr,
  output logic [ADDR_W-1:0]           dest_addr,
  output logic                        src1_en,
  output logic                        src2_en,
  output logic                        dest_en,
  output logic                        addr_last,
  output logic                        busy,
  output logic [ADDR_W-1:0]           imm_out
);

  localparam int DEPTH = 2 ** NS_INDEX_ID_BITS;
  localparam logic [NS_ID_BITS:0] NS_LIMIT = (NS_ID_BITS + 1)'(NUM_NS);
  localparam logic [OPCODE_BITS-1:0] OP_ITER = OPCODE_BITS'(4'b0110);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_tab   [NUM_NS][DEPTH];
  logic [ADDR_W-1:0] stride_tab [NUM_NS][DEPTH];

  logic [IMM_W-1:0] imm;
  logic [IMM_W-1:0] low_hold;
  logic             accept, is_cfg, launch, beat;

  logic                        wr_vld_p1, wr_stride_p1;
  logic [NS_ID_BITS-1:0]       wr_ns_p1;
  logic [NS_INDEX_ID_BITS-1:0] wr_idx_p1;

  logic [NS_ID_BITS-1:0]       l_s1_ns, l_s2_ns, l_d_ns;
  logic [NS_INDEX_ID_BITS-1:0] l_s1_idx, l_s2_idx, l_d_idx;
  logic                        l_s1_use, l_s2_use, l_d_use;
  logic [CNT_W-1:0]            cnt_q;

  logic [ADDR_W-1:0] s1_base, s2_base, d_base;
  logic [ADDR_W-1:0] s1_stride, s2_stride, d_stride;

  function automatic logic ns_ok(input logic [NS_ID_BITS-1:0] ns);
    return {1'b0, ns} < NS_LIMIT;
  endfunction

  // 00 sign-extend, 11 zero-extend, otherwise current imm lands above the held low half
  function automatic logic [ADDR_W-1:0] ext_imm(input logic [1:0] mode,
                                                input logic [IMM_W-1:0] v,
                                                input logic [IMM_W-1:0] low);
    logic signed [IMM_W-1:0]  v_s;
    logic signed [ADDR_W-1:0] v_ext;
    v_s   = v;
    v_ext = ADDR_W'(v_s);
    case (mode)
      2'b00:   return v_ext;
      2'b11:   return {{(ADDR_W-IMM_W){1'b0}}, v};
      default: return {v, low};
    endcase
  endfunction

`ifdef ITER_ADDR_WRAP_EN
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] s);
    logic [ADDR_W-1:0] sum;
    sum = b + s;
    if (sum >= ADDR_W'(ADDR_LIMIT)) return sum - ADDR_W'(ADDR_LIMIT);
    return sum;
  endfunction
`else
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] s);
    return b + s;
  endfunction
`endif

  assign imm        = {src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id};
  assign inst_ready = (state_q == IDLE) && !reset;
  assign accept     = inst_valid && inst_ready;
  assign is_cfg     = accept && (opcode == OP_ITER) && !fn[3] && !loop_start;
  assign launch     = accept && loop_start && (loop_count != '0);

  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign addr_last  = addr_valid && (cnt_q == CNT_W'(1));
  assign beat       = addr_valid && addr_ready;

  // Beat addresses read the live table, so each write-back is visible to the next beat
  assign s1_base   = base_tab[l_s1_ns][l_s1_idx];
  assign s2_base   = base_tab[l_s2_ns][l_s2_idx];
  assign d_base    = base_tab[l_d_ns][l_d_idx];
  assign s1_stride = stride_tab[l_s1_ns][l_s1_idx];
  assign s2_stride = stride_tab[l_s2_ns][l_s2_idx];
  assign d_stride  = stride_tab[l_d_ns][l_d_idx];

  assign src1_addr = addr_valid ? s1_base : '0;
  assign src2_addr = addr_valid ? s2_base : '0;
  assign dest_addr = addr_valid ? d_base  : '0;
  assign src1_en   = addr_valid && l_s1_use;
  assign src2_en   = addr_valid && l_s2_use;
  assign dest_en   = addr_valid && l_d_use;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (beat && addr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0: instruction accept, loop launch, beat counting ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_vld_p1 <= 1'b0;
      low_hold  <= '0;
      imm_out   <= '0;
      l_s1_use  <= 1'b0;
      l_s2_use  <= 1'b0;
      l_d_use   <= 1'b0;
      l_s1_ns   <= '0;
      l_s2_ns   <= '0;
      l_d_ns    <= '0;
      l_s1_idx  <= '0;
      l_s2_idx  <= '0;
      l_d_idx   <= '0;
    end else begin
      state_q   <= state_d;
      wr_vld_p1 <= is_cfg && ns_ok(dest_ns_id);
      if (is_cfg) begin
        imm_out  <= ext_imm(fn[1:0], imm, low_hold);
        low_hold <= imm;
      end
      if (launch) begin
        // Invalid namespaces are parked on entry 0 with the operand disabled
        l_s1_use <= src1_use && ns_ok(src1_ns_id);
        l_s2_use <= src2_use && ns_ok(src2_ns_id);
        l_d_use  <= dest_use && ns_ok(dest_ns_id);
        l_s1_ns  <= ns_ok(src1_ns_id) ? src1_ns_id : '0;
        l_s2_ns  <= ns_ok(src2_ns_id) ? src2_ns_id : '0;
        l_d_ns   <= ns_ok(dest_ns_id) ? dest_ns_id : '0;
        l_s1_idx <= src1_ns_index_id;
        l_s2_idx <= src2_ns_index_id;
        l_d_idx  <= dest_ns_index_id;
        cnt_q    <= loop_count;
      end else if (beat) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_cfg) begin
      wr_stride_p1 <= fn[2];
      wr_ns_p1     <= dest_ns_id;
      wr_idx_p1    <= dest_ns_index_id;
    end
  end

  // ---- p1: table write from registered immediate, and per-beat base write-back ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NS; n++) begin
        for (int i = 0; i < DEPTH; i++) begin
          base_tab[n][i]   <= '0;
          stride_tab[n][i] <= '0;
        end
      end
    end else begin
      if (wr_vld_p1) begin
        if (wr_stride_p1) stride_tab[wr_ns_p1][wr_idx_p1] <= imm_out;
        else              base_tab[wr_ns_p1][wr_idx_p1]   <= imm_out;
      end
      // Aliased operands compute the same value from the old base, so the entry steps once
      if (beat) begin
        if (l_s1_use) base_tab[l_s1_ns][l_s1_idx] <= step_addr(s1_base, s1_stride);
        if (l_s2_use) base_tab[l_s2_ns][l_s2_idx] <= step_addr(s2_base, s2_stride);
        if (l_d_use)  base_tab[l_d_ns][l_d_idx]   <= step_addr(d_base, d_stride);
      end
    end
  end

endmodule

// File: tb/tb_simd_iter_loop_addr_gen.sv
// Directed bench for simd_iter_loop_addr_gen: config decode, loop sequencing, stalls, aliasing, reset.
module tb_simd_iter_loop_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  opcode;
  logic [3:0]  fn;
  logic [2:0]  dest_ns_id, src1_ns_id, src2_ns_id;
  logic [4:0]  dest_ns_index_id, src1_ns_index_id, src2_ns_index_id;
  logic        src1_use, src2_use, dest_use;
  logic        loop_start;
  logic [15:0] loop_count;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] src1_addr, src2_addr, dest_addr;
  logic        src1_en, src2_en, dest_en;
  logic        addr_last;
  logic        busy;
  logic [31:0] imm_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] cap_s1 [8];
  logic [31:0] cap_d  [8];
  logic        cap_last [8];
  logic        cap_s1en [8];
  logic        cap_s2en [8];
  logic        cap_den  [8];
  int          cap_n;
  bit          cap_unstable;
  bit          cap_timeout;

  always #5 clk = ~clk;

  simd_iter_loop_addr_gen dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .opcode(opcode), .fn(fn),
    .dest_ns_id(dest_ns_id), .src1_ns_id(src1_ns_id), .src2_ns_id(src2_ns_id),
    .dest_ns_index_id(dest_ns_index_id), .src1_ns_index_id(src1_ns_index_id),
    .src2_ns_index_id(src2_ns_index_id),
    .src1_use(src1_use), .src2_use(src2_use), .dest_use(dest_use),
    .loop_start(loop_start), .loop_count(loop_count),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dest_addr(dest_addr),
    .src1_en(src1_en), .src2_en(src2_en), .dest_en(dest_en),
    .addr_last(addr_last), .busy(busy), .imm_out(imm_out)
  );

  task automatic send_inst(input logic [3:0] op, input logic [3:0] f,
                           input logic [2:0] dns, input logic [4:0] didx,
                           input logic [15:0] immv, input logic ls,
                           input logic [15:0] n, input logic u1, input logic u2,
                           input logic ud);
    @(negedge clk);
    opcode           = op;
    fn               = f;
    dest_ns_id       = dns;
    dest_ns_index_id = didx;
    {src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id} = immv;
    loop_start       = ls;
    loop_count       = n;
    src1_use         = u1;
    src2_use         = u2;
    dest_use         = ud;
    inst_valid       = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    loop_start = 1'b0;
  endtask

  // Config write, then one more edge so the table write has landed
  task automatic cfg(input logic stride, input logic [1:0] mode, input logic [2:0] ns,
                     input logic [4:0] idx, input logic [15:0] immv);
    send_inst(4'b0110, {1'b0, stride, mode}, ns, idx, immv, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] s1ns, input logic [4:0] s1idx,
                        input logic [2:0] dns, input logic [4:0] didx,
                        input logic [15:0] n, input logic u1, input logic ud);
    send_inst(4'b0110, 4'b1000, dns, didx, {s1ns, s1idx, 3'd0, 5'd0}, 1'b1, n, u1, 1'b0, ud);
  endtask

  task automatic collect(input int n, input bit toggle);
    logic [31:0] h_s1, h_d;
    logic        h_last;
    bit          held;
    held = 0;
    h_s1 = '0;
    h_d = '0;
    h_last = 1'b0;
    cap_n = 0;
    cap_unstable = 0;
    cap_timeout = 0;
    addr_ready = toggle;
    for (int cyc = 0; cyc < 64 && cap_n < n; cyc++) begin
      @(negedge clk);
      addr_ready = toggle ? ~addr_ready : 1'b1;
      if (addr_valid) begin
        if (held && (src1_addr !== h_s1 || dest_addr !== h_d || addr_last !== h_last))
          cap_unstable = 1;
        if (addr_ready) begin
          cap_s1[cap_n]   = src1_addr;
          cap_d[cap_n]    = dest_addr;
          cap_last[cap_n] = addr_last;
          cap_s1en[cap_n] = src1_en;
          cap_s2en[cap_n] = src2_en;
          cap_den[cap_n]  = dest_en;
          cap_n++;
          held = 0;
        end else begin
          held   = 1;
          h_s1   = src1_addr;
          h_d    = dest_addr;
          h_last = addr_last;
        end
      end
    end
    if (cap_n < n) cap_timeout = 1;
    @(posedge clk);
    #1;
    addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (inst_ready !== 1'b0) begin mismatched++; $display("FAIL reset_inst_ready got %b want 0", inst_ready); end
    compared++;
    if ({addr_valid, busy, addr_last, src1_en, src2_en, dest_en} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl got %b want 000000", {addr_valid, busy, addr_last, src1_en, src2_en, dest_en});
    end
    compared++;
    if ({src1_addr, src2_addr, dest_addr, imm_out} !== 128'b0) begin
      mismatched++;
      $display("FAIL reset_data got %h %h %h %h want 0", src1_addr, src2_addr, dest_addr, imm_out);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (inst_ready !== 1'b1) begin mismatched++; $display("FAIL idle_inst_ready got %b want 1", inst_ready); end
  endtask

  task automatic test_cfg_extend();
    cfg(1'b0, 2'b00, 3'd1, 5'd3, 16'h8010);
    compared++;
    if (imm_out !== 32'hFFFF8010) begin mismatched++; $display("FAIL sext_imm_out got %h want FFFF8010", imm_out); end
    launch(3'd1, 5'd3, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'hFFFF8010) begin
      mismatched++; $display("FAIL sext_table got %h want FFFF8010", cap_s1[0]);
    end
    cfg(1'b0, 2'b11, 3'd1, 5'd3, 16'h8010);
    compared++;
    if (imm_out !== 32'h00008010) begin mismatched++; $display("FAIL zext_imm_out got %h want 00008010", imm_out); end
    launch(3'd1, 5'd3, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'h00008010) begin
      mismatched++; $display("FAIL zext_table got %h want 00008010", cap_s1[0]);
    end
  endtask

  task automatic test_assemble();
    cfg(1'b0, 2'b00, 3'd1, 5'd4, 16'h1234);
    cfg(1'b0, 2'b01, 3'd1, 5'd4, 16'h00AB);
    compared++;
    if (imm_out !== 32'h00AB1234) begin mismatched++; $display("FAIL asm_imm_out got %h want 00AB1234", imm_out); end
    launch(3'd1, 5'd4, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'h00AB1234) begin
      mismatched++; $display("FAIL asm_table got %h want 00AB1234", cap_s1[0]);
    end
  endtask

  task automatic test_loop(input bit toggle);
    logic [31:0] exp_a [3];
    exp_a = '{32'd100, 32'd104, 32'd108};
    cfg(1'b0, 2'b00, 3'd2, 5'd0, 16'd100);
    cfg(1'b1, 2'b00, 3'd2, 5'd0, 16'd4);
    launch(3'd2, 5'd0, 3'd0, 5'd0, 16'd3, 1'b1, 1'b0);
    collect(3, toggle);
    compared++;
    if (cap_timeout || cap_n != 3) begin mismatched++; $display("FAIL loop_beats got %0d want 3", cap_n); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (cap_s1[i] !== exp_a[i] || cap_last[i] !== (i == 2)) begin
        mismatched++;
        $display("FAIL loop_beat%0d got %0d/last %b want %0d/last %b", i, cap_s1[i], cap_last[i], exp_a[i], (i == 2));
      end
      compared++;
      if ({cap_s1en[i], cap_s2en[i], cap_den[i]} !== 3'b100) begin
        mismatched++; $display("FAIL loop_en%0d got %b want 100", i, {cap_s1en[i], cap_s2en[i], cap_den[i]});
      end
    end
    compared++;
    if (cap_unstable) begin mismatched++; $display("FAIL loop_stall_hold got unstable want stable"); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL loop_done_busy got %b want 0", busy); end
    launch(3'd2, 5'd0, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'd112) begin mismatched++; $display("FAIL loop_final_base got %0d want 112", cap_s1[0]); end
  endtask

  task automatic test_alias();
    cfg(1'b0, 2'b00, 3'd0, 5'd5, 16'd0);
    cfg(1'b1, 2'b00, 3'd0, 5'd5, 16'd8);
    launch(3'd0, 5'd5, 3'd0, 5'd5, 16'd2, 1'b1, 1'b1);
    collect(2, 0);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (cap_timeout || cap_s1[i] !== 32'(8 * i) || cap_d[i] !== 32'(8 * i) || cap_den[i] !== 1'b1) begin
        mismatched++;
        $display("FAIL alias_beat%0d got %0d/%0d en %b want %0d/%0d en 1", i, cap_s1[i], cap_d[i], cap_den[i], 8 * i, 8 * i);
      end
    end
    launch(3'd0, 5'd5, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'd16) begin mismatched++; $display("FAIL alias_final_base got %0d want 16", cap_s1[0]); end
  endtask

  task automatic test_zero_and_bad_ns();
    launch(3'd2, 5'd0, 3'd0, 5'd0, 16'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, addr_valid, inst_ready} !== 3'b001) begin
      mismatched++; $display("FAIL zero_count got %b want 001", {busy, addr_valid, inst_ready});
    end
    launch(3'd7, 5'd0, 3'd2, 5'd0, 16'd1, 1'b1, 1'b1);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1en[0] !== 1'b0 || cap_den[0] !== 1'b1) begin
      mismatched++; $display("FAIL bad_ns_en got s1 %b d %b want s1 0 d 1", cap_s1en[0], cap_den[0]);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_b;
`ifdef ITER_ADDR_WRAP_EN
    exp_b = 32'd8;
`else
    exp_b = 32'd4104;
`endif
    cfg(1'b0, 2'b00, 3'd3, 5'd1, 16'd4088);
    cfg(1'b1, 2'b00, 3'd3, 5'd1, 16'd16);
    launch(3'd3, 5'd1, 3'd0, 5'd0, 16'd2, 1'b1, 1'b0);
    collect(2, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'd4088 || cap_s1[1] !== exp_b) begin
      mismatched++; $display("FAIL wrap_seq got %0d,%0d want 4088,%0d", cap_s1[0], cap_s1[1], exp_b);
    end
    launch(3'd3, 5'd1, 3'd0, 5'd0, 16'd5, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL midloop_busy got %b want 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    compared++;
    if (inst_ready !== 1'b0) begin mismatched++; $display("FAIL midloop_inst_ready got %b want 0", inst_ready); end
    @(posedge clk);
    #1;
    compared++;
    if ({addr_valid, busy, addr_last, src1_addr} !== 35'b0) begin
      mismatched++; $display("FAIL midloop_abort got v%b b%b l%b a%h want all 0", addr_valid, busy, addr_last, src1_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    launch(3'd3, 5'd1, 3'd0, 5'd0, 16'd1, 1'b1, 1'b0);
    collect(1, 0);
    compared++;
    if (cap_timeout || cap_s1[0] !== 32'd0) begin mismatched++; $display("FAIL table_cleared got %0d want 0", cap_s1[0]); end
  endtask

  initial begin
    reset = 1'b1;
    inst_valid = 1'b0;
    opcode = '0;
    fn = '0;
    dest_ns_id = '0;
    src1_ns_id = '0;
    src2_ns_id = '0;
    dest_ns_index_id = '0;
    src1_ns_index_id = '0;
    src2_ns_index_id = '0;
    src1_use = 1'b0;
    src2_use = 1'b0;
    dest_use = 1'b0;
    loop_start = 1'b0;
    loop_count = '0;
    addr_ready = 1'b0;
    test_reset();
    test_cfg_extend();
    test_assemble();
    test_loop(0);
    test_loop(1);
    test_alias();
    test_zero_and_bad_ns();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
